// File: rtl/mem_fetch_pkg.sv
// Shared memory/fetch constants: word-address width and word width,
// used by the fetch unit and by the instruction memory.
package mem_fetch_pkg;
    localparam int LGMEMSZ = 14;
    localparam int WORD_W  = 32;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mem_fetch_fifo.sv
// Two-entry {data, pc} buffer between the memory response and the
// consumer; clear drops everything, pushes are refused when full.
module fetch_fifo
    import mem_fetch_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  word_t         i_data,
    input  logic [AW-1:0] i_pc,
    input  logic          i_pop,
    output logic [1:0]    o_count,
    output word_t         o_data,
    output logic [AW-1:0] o_pc
);

    word_t         r_data [2];
    logic [AW-1:0] r_pc   [2];
    logic          r_rd;
    logic          r_wr;
    logic [1:0]    r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= i_data;
                r_pc[r_wr]   <= i_pc;
                r_wr         <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_count = r_count;
    assign o_data  = r_data[r_rd];
    assign o_pc    = r_pc[r_rd];

endmodule

// File: rtl/mem_fetch.sv
// Sequential instruction fetch from a one-cycle-latency memory with
// redirect support and a two-entry output buffer.
module mem_fetch #(
    parameter int                     LGMEMSZ  = mem_fetch_pkg::LGMEMSZ,
    parameter logic [LGMEMSZ-1:0]     RESET_PC = '0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    output logic                      o_read,
    output logic [LGMEMSZ-1:0]        o_address,
    input  mem_fetch_pkg::word_t      i_data,
    input  logic                      i_redirect,
    input  logic [LGMEMSZ-1:0]        i_target,
    output logic                      o_valid,
    input  logic                      i_ready,
    output mem_fetch_pkg::word_t      o_instr,
    output logic [LGMEMSZ-1:0]        o_pc
);

    logic [LGMEMSZ-1:0]   r_pc;
    logic [LGMEMSZ-1:0]   r_issue_pc;
    logic                 r_pending;
    logic                 r_discard;

    logic [1:0]           w_count;
    logic [1:0]           w_occ;
    mem_fetch_pkg::word_t w_head_data;
    logic [LGMEMSZ-1:0]   w_head_pc;
    logic                 w_has_word;
    logic                 w_hs;
    logic                 w_push;

    // Buffered words plus the one in flight must never exceed two,
    // unless a pop this cycle frees a slot for the new response.
    assign w_has_word = (w_count != 2'd0) && !i_reset;
    assign w_hs       = w_has_word && i_ready;
    assign w_occ      = w_count + {1'b0, r_pending};
    assign o_read     = !i_reset && !i_redirect &&
                        ((w_occ < 2'd2) || w_hs);
    assign o_address  = r_pc;
    assign w_push     = r_pending && !r_discard;

    fetch_fifo #(
        .AW      (LGMEMSZ)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_redirect),
        .i_push  (w_push),
        .i_data  (i_data),
        .i_pc    (r_issue_pc),
        .i_pop   (w_hs),
        .o_count (w_count),
        .o_data  (w_head_data),
        .o_pc    (w_head_pc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_issue_pc <= '0;
            r_pending  <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_pending <= o_read;
            r_discard <= i_redirect;
            if (i_redirect) begin
                r_pc <= i_target;
            end else if (o_read) begin
                r_pc <= r_pc + 1'b1;
            end
            if (o_read) begin
                r_issue_pc <= r_pc;
            end
        end
    end

    assign o_valid = w_has_word;
    assign o_instr = w_has_word ? w_head_data : '0;
    assign o_pc    = w_has_word ? w_head_pc : '0;

endmodule

// File: tb/tb_mem_fetch.sv
// Bench for mem_fetch: memory word[i] = 0x1000 + i, scoreboard of
// expected fetch addresses checked on every consumer handshake.
module tb_mem_fetch;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          o_read;
    logic [AW-1:0] o_address;
    logic [31:0]   i_data;
    logic          i_redirect;
    logic [AW-1:0] i_target;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_instr;
    logic [AW-1:0] o_pc;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] sb_pc;

    always #5 clk = ~clk;

    mem_fetch #(
        .LGMEMSZ    (AW),
        .RESET_PC   (14'h0000)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .o_read     (o_read),
        .o_address  (o_address),
        .i_data     (i_data),
        .i_redirect (i_redirect),
        .i_target   (i_target),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_instr    (o_instr),
        .o_pc       (o_pc)
    );

    // One-cycle-latency memory; garbage when no read was issued.
    always @(posedge clk) begin
        if (o_read) i_data <= 32'h1000 + {18'd0, o_address};
        else        i_data <= 32'hDEAD_0000;
    end

    always @(negedge clk) begin
        if (o_valid && i_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got pc=%h instr=%h, wanted no word",
                         o_pc, o_instr);
            end else begin
                sb_pc = exp_q.pop_front();
                if (o_pc !== sb_pc ||
                    o_instr !== (32'h1000 + {18'd0, sb_pc})) begin
                    n_fail++;
                    $display("FAIL sb_word: got pc=%h instr=%h, wanted pc=%h instr=%h",
                             o_pc, o_instr, sb_pc, 32'h1000 + {18'd0, sb_pc});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] p;
        p = start;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(p);
            p = p + 1'b1;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_tests++;
        if ({o_read, o_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_strobes: got read,valid=%b, wanted 00",
                     {o_read, o_valid});
        end
        n_tests++;
        if (o_instr !== 32'h0 || o_pc !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_data: got instr=%h pc=%h, wanted 0 0",
                     o_instr, o_pc);
        end
    endtask

    task automatic test_stream();
        push_stream(14'h0000, 256);
        tick();
        i_reset = 1'b0;
        #1;
        n_tests++;
        if (o_read !== 1'b1 || o_address !== 14'h0000) begin
            n_fail++;
            $display("FAIL first_read: got read=%b addr=%h, wanted 1 0000",
                     o_read, o_address);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_c1: got valid=%b, wanted 0", o_valid);
        end
        n_tests++;
        if (o_read !== 1'b1 || o_address !== 14'h0001) begin
            n_fail++;
            $display("FAIL second_read: got read=%b addr=%h, wanted 1 0001",
                     o_read, o_address);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b1 || o_instr !== 32'h1000 || o_pc !== 14'h0) begin
            n_fail++;
            $display("FAIL lat_c2: got valid=%b instr=%h pc=%h, wanted 1 00001000 0000",
                     o_valid, o_instr, o_pc);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_tests++;
            if (o_valid !== 1'b1 || o_pc !== AW'(k)) begin
                n_fail++;
                $display("FAIL throughput: got valid=%b pc=%h, wanted 1 %h",
                         o_valid, o_pc, AW'(k));
            end
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] hpc;
        logic [31:0]   hinstr;
        tick();
        i_ready = 1'b0;
        #1;
        hpc    = o_pc;
        hinstr = o_instr;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (o_valid !== 1'b1 || o_pc !== hpc || o_instr !== hinstr) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b pc=%h instr=%h, wanted 1 %h %h",
                         o_valid, o_pc, o_instr, hpc, hinstr);
            end
            n_tests++;
            if (o_read !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_full: got read=%b, wanted 0", o_read);
            end
        end
        tick();
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_redirect_full();
        tick();
        i_ready    = 1'b0;
        i_redirect = 1'b1;
        i_target   = 14'h0100;
        #1;
        n_tests++;
        if (o_read !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_noread: got read=%b, wanted 0", o_read);
        end
        tick();
        i_redirect = 1'b0;
        i_ready    = 1'b1;
        push_stream(14'h0100, 256);
        #1;
        n_tests++;
        if (o_read !== 1'b1 || o_address !== 14'h0100 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_first_read: got read=%b addr=%h valid=%b, wanted 1 0100 0",
                     o_read, o_address, o_valid);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_lat2: got valid=%b, wanted 0", o_valid);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b1 || o_pc !== 14'h0100 || o_instr !== 32'h1100) begin
            n_fail++;
            $display("FAIL redir_lat3: got valid=%b pc=%h instr=%h, wanted 1 0100 00001100",
                     o_valid, o_pc, o_instr);
        end
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] wl [4];
        wl[0] = 14'h3FFE;
        wl[1] = 14'h3FFF;
        wl[2] = 14'h0000;
        wl[3] = 14'h0001;
        tick();
        i_redirect = 1'b1;
        i_target   = 14'h3FFE;
        tick();
        i_redirect = 1'b0;
        push_stream(14'h3FFE, 256);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_pc !== wl[k]) begin
                n_fail++;
                $display("FAIL wrap_seq: got valid=%b pc=%h, wanted 1 %h",
                         o_valid, o_pc, wl[k]);
            end
            tick();
        end
    endtask

    task automatic test_hs_redirect();
        tick();
        i_redirect = 1'b1;
        i_target   = 14'h0200;
        #1;
        n_tests++;
        if (o_valid !== 1'b1 || exp_q.size() == 0 || o_pc !== exp_q[0]) begin
            n_fail++;
            $display("FAIL hs_redir_head: got valid=%b pc=%h, wanted 1 and next expected word",
                     o_valid, o_pc);
        end
        tick();
        i_redirect = 1'b0;
        push_stream(14'h0200, 256);
        #1;
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_redir_empty1: got valid=%b, wanted 0", o_valid);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_redir_empty2: got valid=%b, wanted 0", o_valid);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b1 || o_pc !== 14'h0200) begin
            n_fail++;
            $display("FAIL hs_redir_new: got valid=%b pc=%h, wanted 1 0200",
                     o_valid, o_pc);
        end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_back_to_back();
        tick();
        i_redirect = 1'b1;
        i_target   = 14'h0300;
        tick();
        i_target   = 14'h0500;
        #1;
        n_tests++;
        if (o_read !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_noread: got read=%b, wanted 0", o_read);
        end
        tick();
        i_redirect = 1'b0;
        push_stream(14'h0500, 256);
        #1;
        n_tests++;
        if (o_read !== 1'b1 || o_address !== 14'h0500) begin
            n_fail++;
            $display("FAIL b2b_read: got read=%b addr=%h, wanted 1 0500",
                     o_read, o_address);
        end
        tick();
        tick();
        n_tests++;
        if (o_valid !== 1'b1 || o_pc !== 14'h0500) begin
            n_fail++;
            $display("FAIL b2b_new: got valid=%b pc=%h, wanted 1 0500",
                     o_valid, o_pc);
        end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_reset_mid();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        push_stream(14'h0000, 256);
        #1;
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_valid: got valid=%b, wanted 0", o_valid);
        end
        n_tests++;
        if (o_read !== 1'b1 || o_address !== 14'h0000) begin
            n_fail++;
            $display("FAIL rst_mid_read: got read=%b addr=%h, wanted 1 0000",
                     o_read, o_address);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_lat1: got valid=%b, wanted 0", o_valid);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b1 || o_pc !== 14'h0000 || o_instr !== 32'h1000) begin
            n_fail++;
            $display("FAIL rst_mid_first: got valid=%b pc=%h instr=%h, wanted 1 0000 00001000",
                     o_valid, o_pc, o_instr);
        end
        for (int c = 0; c < 3; c++) tick();
    endtask

    initial begin
        i_reset    = 1'b1;
        i_redirect = 1'b0;
        i_ready    = 1'b1;
        i_target   = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_hs_redirect();
        test_back_to_back();
        test_reset_mid();
        tick();
        i_ready = 1'b0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
